// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between the requesters and the FIFO write arbiter.
// The master side is the arbiter, the slave side is the requesters plus the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    localparam int OW = $clog2(NREQ);

    logic [NREQ-1:0]        req_i;
    logic [NREQ*DWIDTH-1:0] data_i;
    logic                   full_i;
    logic [NREQ-1:0]        gnt_o;
    logic                   wenc_o;
    logic [DWIDTH-1:0]      wdata_o;
    logic                   busy_o;
    logic [OW-1:0]          owner_o;

    modport master (
        input  req_i,
        input  data_i,
        input  full_i,
        output gnt_o,
        output wenc_o,
        output wdata_o,
        output busy_o,
        output owner_o
    );

    modport slave (
        output req_i,
        output data_i,
        output full_i,
        input  gnt_o,
        input  wenc_o,
        input  wdata_o,
        input  busy_o,
        input  owner_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// An owner keeps the port for up to MAX_BURST beats; one IDLE cycle between grants.
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DWIDTH    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int OW = $clog2(NREQ);
    localparam int SW = OW + 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [OW-1:0] LAST  = OW'(NREQ - 1);
    localparam logic [CW-1:0] CLAST = CW'(MAX_BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t            state;
    logic [OW-1:0]     owner;
    logic [OW-1:0]     ptr;
    logic [OW-1:0]     pick;
    logic [SW-1:0]     sum;
    logic [CW-1:0]     cnt;
    logic              hold;
    logic              accept;
    logic              last_beat;
    logic              release_now;
    logic [DWIDTH-1:0] slot [NREQ];

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign slot[k] = bus.data_i[k*DWIDTH +: DWIDTH];
    end

    // Lowest rotation distance from ptr wins, so scan farthest first.
    always_comb begin
        pick = ptr;
        sum  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
            if (bus.req_i[sum[OW-1:0]]) pick = sum[OW-1:0];
        end
    end

    assign hold        = bus.req_i[owner];
    assign accept      = (state == GRANT) && hold && !bus.full_i;
    assign last_beat   = (cnt == CLAST);
    assign release_now = !hold || (accept && last_beat);

    assign bus.gnt_o   = accept ? (NREQ'(1) << owner) : '0;
    assign bus.wenc_o  = accept;
    assign bus.busy_o  = (state == GRANT);
    assign bus.owner_o = owner;
    assign bus.wdata_o = (state == GRANT) ? slot[owner] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|bus.req_i) begin
                        owner <= pick;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        cnt   <= '0;
                        ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
                    end else if (accept) begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester expected beat queues,
// cycle pattern checks, stall/drop/reset scenarios and a FIFO-fill stress run.
module tb_fifo_wr_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MB   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

    fifo_wr_arbiter #(
        .NREQ(NREQ),
        .DWIDTH(DW),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q [NREQ][$];
    int         own_q [$];
    int         rem [NREQ];
    logic [5:0] seq [NREQ];
    logic [5:0] nxt [NREQ];
    logic [31:0] trace;
    int nwr, fcnt, cyc, n;
    bit fifo_mode, full_force, busy_prev, saw_full;

    logic       s_wenc, s_busy;
    logic [3:0] s_gnt;
    logic [7:0] s_wdata;
    logic [1:0] s_owner;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < NREQ; k++) s += rem[k] + exp_q[k].size();
        return s;
    endfunction

    task automatic apply();
        for (int k = 0; k < NREQ; k++) begin
            bus.req_i[k] = (rem[k] > 0);
            bus.data_i[k*DW +: DW] = {2'(k), seq[k]};
        end
        bus.full_i = fifo_mode ? (fcnt >= 32) : full_force;
        if (bus.full_i && fifo_mode) saw_full = 1'b1;
    endtask

    task automatic load(input int k, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_q[k].push_back({2'(k), nxt[k]});
            nxt[k]++;
        end
        rem[k] += cnt;
        apply();
    endtask

    task automatic new_scn();
        for (int k = 0; k < NREQ; k++) begin
            rem[k] = 0;
            seq[k] = '0;
            nxt[k] = '0;
            exp_q[k].delete();
        end
        own_q.delete();
        fifo_mode  = 1'b0;
        full_force = 1'b0;
        busy_prev  = 1'b0;
        saw_full   = 1'b0;
        nwr = 0;
        fcnt = 0;
        cyc = 0;
        apply();
    endtask

    task automatic cycle();
        logic [3:0] oh;
        @(negedge clk);
        s_wenc  = bus.wenc_o;
        s_gnt   = bus.gnt_o;
        s_busy  = bus.busy_o;
        s_owner = bus.owner_o;
        s_wdata = bus.wdata_o;
        if (s_wenc) begin
            oh = 4'b1 << s_owner;
            chk("gnt_onehot", s_gnt, oh);
            chk("q_has_beat", exp_q[s_owner].size() > 0, 1);
            if (exp_q[s_owner].size() > 0)
                chk("wdata", s_wdata, exp_q[s_owner].pop_front());
            nwr++;
            fcnt++;
        end else begin
            chk("gnt_idle", s_gnt, 0);
        end
        if (bus.full_i) chk("no_wr_full", s_wenc, 0);
        if (s_busy && !busy_prev) own_q.push_back(int'(s_owner));
        busy_prev = s_busy;
        trace = {trace[30:0], s_wenc};
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (s_gnt[k] && rem[k] > 0) begin
                rem[k]--;
                seq[k]++;
            end
        end
        cyc++;
        if (fifo_mode && cyc % 8 == 0 && fcnt > 0) fcnt--;
        apply();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (pending() > 0 && used < budget) begin
            cycle();
            used++;
        end
        chk("drain_in_time", used < budget, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_own [5];
        exp_own = '{0, 1, 2, 3, 0};
        trace = '0;

        // Reset with every request raised
        new_scn();
        for (int k = 0; k < NREQ; k++) rem[k] = 1;
        apply();
        #12;
        chk("rst_outputs", {bus.gnt_o, bus.wenc_o, bus.wdata_o,
                            bus.busy_o, bus.owner_o}, 0);
        cycle();
        cycle();
        chk("rst_hold_busy", s_busy, 0);
        new_scn();
        rst_n = 1'b1;

        // Single requester: 4 writes then one idle cycle
        load(0, 8);
        trace = '0;
        repeat (10) cycle();
        chk("single_pattern", trace[9:0], 10'b0111101111);
        chk("single_done", pending(), 0);

        // Round robin with all requesters pending
        new_scn();
        do_reset();
        load(0, 8);
        load(1, 4);
        load(2, 4);
        load(3, 4);
        drain(100, n);
        chk("rr_cycles", n, 25);
        chk("rr_grants", own_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < own_q.size()) chk("rr_owner", own_q[i], exp_own[i]);

        // Full stall mid-burst, then burst-limit release with request held
        new_scn();
        do_reset();
        load(1, 6);
        repeat (3) cycle();
        full_force = 1'b1;
        apply();
        repeat (5) begin
            cycle();
            chk("stall", {s_wenc, s_gnt, s_busy, s_owner},
                {1'b0, 4'b0, 1'b1, 2'd1});
        end
        full_force = 1'b0;
        apply();
        trace = '0;
        repeat (3) cycle();
        chk("stall_resume", trace[2:0], 3'b110);
        chk("stall_release", s_busy, 0);
        chk("stall_left", rem[1], 2);
        drain(20, n);

        // Early drop by owner 2, then search starts at 3
        new_scn();
        do_reset();
        load(2, 1);
        cycle();
        cycle();
        chk("drop_beat", {s_wenc, s_owner}, {1'b1, 2'd2});
        cycle();
        chk("drop_nowrite", {s_wenc, s_busy}, 2'b01);
        load(0, 1);
        load(2, 1);
        cycle();
        chk("drop_idle", s_busy, 0);
        cycle();
        chk("drop_next_owner", {s_busy, s_owner}, {1'b1, 2'd0});
        drain(20, n);

        // Asynchronous reset in the middle of owner 3's burst
        new_scn();
        do_reset();
        load(3, 4);
        repeat (3) cycle();
        chk("pre_rst_owner", {s_busy, s_owner}, {1'b1, 2'd3});
        rst_n = 1'b0;
        #1;
        chk("rst_async", {bus.gnt_o, bus.wenc_o, bus.wdata_o,
                          bus.busy_o, bus.owner_o}, 0);
        cycle();
        load(0, 1);
        rst_n = 1'b1;
        own_q.delete();
        busy_prev = 1'b0;
        drain(40, n);
        chk("rst_grants", own_q.size(), 2);
        if (own_q.size() > 1) begin
            chk("rst_first_owner", own_q[0], 0);
            chk("rst_second_owner", own_q[1], 3);
        end

        // Stress against a 32-deep FIFO drained slowly
        new_scn();
        do_reset();
        fifo_mode = 1'b1;
        load(0, 14);
        load(1, 13);
        load(2, 13);
        drain(1500, n);
        chk("stress_writes", nwr, 40);
        chk("stress_saw_full", saw_full, 1);
        chk("stress_left", pending(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of write requesters sharing one async_fifo write port (2..8).
REQ-002 Parameter DWIDTH, default 8, data width, equal to the FIFO DWIDTH.
REQ-003 Parameter MAX_BURST, default 4, maximum beats one owner writes per grant (1..16).
REQ-004 clk  input  1  write-side clock, same clock as the FIFO wclk; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  NREQ  per-requester write request, level, held while data pending.
REQ-007 data_i  input  NREQ*DWIDTH  requester k data in bits [k*DWIDTH +: DWIDTH].
REQ-008 full_i  input  1  FIFO full flag (full_o of the FIFO), combinational use allowed.
REQ-009 gnt_o  output  NREQ  one-hot beat-accept strobe; requester k presents next data after a cycle with gnt_o[k]=1.
REQ-010 wenc_o  output  1  FIFO write enable (to wenc_i).
REQ-011 wdata_o  output  DWIDTH  FIFO write data (to wdata_i).
REQ-012 busy_o  output  1  high while a grant is held (state GRANT).
REQ-013 owner_o  output  $clog2(NREQ)  index of current owner; valid when busy_o=1.

Function
REQ-014 Two-state FSM: IDLE, GRANT; registers: owner, round-robin pointer ptr, beat counter cnt (width $clog2(MAX_BURST+1)).
REQ-015 IDLE: no grant, wenc_o=0; if any req_i bit set, owner <= first set index searching ptr, ptr+1, ... wrapping mod NREQ; cnt <= 0; next state GRANT.
REQ-016 IDLE with req_i=0: remain IDLE, ptr unchanged.
REQ-017 GRANT: beat accept = req_i[owner] & !full_i; gnt_o[owner] = wenc_o = accept (combinational, same cycle); all other gnt_o bits 0.
REQ-018 wdata_o = data_i slice of owner whenever busy_o=1; 0 when IDLE.
REQ-019 Each accepted beat increments cnt by 1; full_i=1 stalls: no accept, cnt unchanged, stay GRANT.
REQ-020 Grant release to IDLE occurs on: (a) req_i[owner]=0 (no write that cycle), or (b) accepted beat with cnt==MAX_BURST-1 (the write does occur).
REQ-021 On release ptr <= (owner+1) mod NREQ; releases never skip a waiting requester for more than NREQ-1 grants.
REQ-022 Re-arbitration costs exactly one IDLE cycle; first beat of any grant is accepted no earlier than the cycle after req_i is sampled in IDLE.
REQ-023 Requests from non-owners during GRANT are ignored until the next IDLE cycle.
REQ-024 Maximum throughput: MAX_BURST beats per MAX_BURST+1 cycles when not full.
REQ-025 full_i and req_i[owner] falling in the same cycle: release per REQ-020(a), no write.
REQ-026 Never asserts wenc_o while full_i=1 (FIFO overflow impossible).
REQ-027 A stall of any length on full_i holds owner; no timeout.

Reset
REQ-028 rst_n low asynchronously forces state IDLE, owner 0, ptr 0, cnt 0; gnt_o=0, wenc_o=0, wdata_o=0, busy_o=0, owner_o=0.
REQ-029 Reset asserted mid-burst aborts the burst; beats not yet granted are not written; first post-reset grant searches from index 0.
REQ-030 Outputs depend only on reset state while rst_n low, regardless of req_i/full_i.

Verification
REQ-031 Single requester: NREQ=4, MAX_BURST=4, req_i=0001 held, full_i=0 -> pattern 4 writes then 1 idle cycle, repeating; wdata_o matches data_i[7:0] per beat.
REQ-032 Round-robin: req_i=1111 held -> owners 0,1,2,3,0 in order, 4 beats each, ptr wraps 3->0.
REQ-033 Full stall: owner 1 mid-burst cnt=2, full_i=1 for 5 cycles -> wenc_o=0, gnt_o=0, busy_o=1, owner_o=1 throughout; after full_i=0 exactly 2 more beats then release.
REQ-034 Early drop: owner 2 drops req_i after 1 beat -> that cycle no write, IDLE next, ptr=3; req_i=0101 then grants owner 0 (search 3,0).
REQ-035 Reset mid-burst: rst_n low asynchronously during GRANT owner 3 -> all outputs 0 before next clk edge; after release with req_i=1001 owner 0 granted.
REQ-036 Integration with async_fifo (DEPTH=32): 40 beats from 3 requesters, slow rclk reader -> no write while full_o, read sequence equals grant order, no data lost or duplicated.
